// File: rtl/multi_phase_signal_ctrl_pkg.sv
// Shared types and constants for the multi-phase intersection controller.
package multi_phase_signal_ctrl_pkg;

  typedef enum logic [2:0] {
    StAllRed  = 3'd0,
    StGreen   = 3'd1,
    StExtend  = 3'd2,
    StYellow  = 3'd3,
    StWalk    = 3'd4,
    StPreempt = 3'd5
  } state_e;

  localparam logic [2:0] SEL_BASE   = 3'd0;
  localparam logic [2:0] SEL_EXT    = 3'd1;
  localparam logic [2:0] SEL_YEL    = 3'd2;
  localparam logic [2:0] SEL_ALLRED = 3'd3;
  localparam logic [2:0] SEL_WALK   = 3'd4;

  localparam int unsigned DEF_BASE_T   = 6;
  localparam int unsigned DEF_EXT_T    = 3;
  localparam int unsigned DEF_YEL_T    = 2;
  localparam int unsigned DEF_ALLRED_T = 1;
  localparam int unsigned DEF_WALK_T   = 4;
  localparam int unsigned DEF_MAX_EXT  = 2;

endpackage

// File: rtl/multi_phase_signal_ctrl_phase_timer.sv
// Tick-driven countdown for one state dwell; a loaded duration of 0 counts as 1.
module multi_phase_signal_ctrl_phase_timer #(
  parameter int unsigned TW        = 8,
  parameter int unsigned RESET_VAL = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          hold,
  input  logic          tick,
  input  logic [TW-1:0] duration,
  output logic          expired
);

  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [TW-1:0] INIT_VAL = (RESET_VAL == 0) ? TW'(1) : TW'(RESET_VAL);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= INIT_VAL;
    end else if (load) begin
      count_q <= (duration == '0) ? ONE : duration;
    end else if (tick && !hold && (count_q > ONE)) begin
      count_q <= count_q - ONE;
    end
  end

  assign expired = tick && !hold && (count_q == ONE);

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// N-approach demand-driven round-robin signal controller with extension, clearance and walk.
// Optional emergency preemption is built when SIGNAL_PREEMPT_EN is defined.
module multi_phase_signal_ctrl
  import multi_phase_signal_ctrl_pkg::*;
#(
  parameter int unsigned N_PHASES = 4,
  parameter int unsigned TW       = 8,
  parameter int unsigned BASE_T   = DEF_BASE_T,
  parameter int unsigned EXT_T    = DEF_EXT_T,
  parameter int unsigned YEL_T    = DEF_YEL_T,
  parameter int unsigned ALLRED_T = DEF_ALLRED_T,
  parameter int unsigned WALK_T   = DEF_WALK_T,
  parameter int unsigned MAX_EXT  = DEF_MAX_EXT
) (
  input  logic                        clk,
  input  logic                        reset_n,
`ifdef SIGNAL_PREEMPT_EN
  input  logic                        preempt,
  input  logic [$clog2(N_PHASES)-1:0] preempt_phase,
`endif
  input  logic                        tick,
  input  logic [N_PHASES-1:0]         sensor,
  input  logic [N_PHASES-1:0]         walk_req,
  input  logic                        prog_we,
  input  logic [2:0]                  prog_sel,
  input  logic [TW-1:0]               prog_data,
  output logic [N_PHASES-1:0]         red,
  output logic [N_PHASES-1:0]         yellow,
  output logic [N_PHASES-1:0]         green,
  output logic [N_PHASES-1:0]         walk,
  output logic [$clog2(N_PHASES)-1:0] cur_phase,
  output logic [2:0]                  state,
  output logic [N_PHASES-1:0]         walk_pending,
  output logic                        fault
);

  localparam int unsigned PW = $clog2(N_PHASES);
  localparam int unsigned EW = $clog2(MAX_EXT + 2);
  localparam logic [PW-1:0] LAST = PW'(N_PHASES - 1);

  state_e              state_q, state_d;
  logic [PW-1:0]       cur_q, cur_d, next_phase, idx;
  logic [EW-1:0]       ext_cnt_q, ext_cnt_d;
  logic                fault_q, fault_d;
  logic [N_PHASES-1:0] walk_pending_q, walk_pending_d, walk_clr, demand;
  logic [N_PHASES-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d, walk_q, walk_d;
  logic [TW-1:0]       dur_base_q, dur_ext_q, dur_yel_q, dur_allred_q, dur_walk_q, load_dur;
  logic                load, hold, expired, ext_ok, walk_exit, preempt_now;

`ifdef SIGNAL_PREEMPT_EN
  assign preempt_now = preempt;
  assign hold        = (state_q == StPreempt);
`else
  assign preempt_now = 1'b0;
  assign hold        = 1'b0;
`endif

  // Shadow duration registers; a write only affects the next timer load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dur_base_q   <= TW'(BASE_T);
      dur_ext_q    <= TW'(EXT_T);
      dur_yel_q    <= TW'(YEL_T);
      dur_allred_q <= TW'(ALLRED_T);
      dur_walk_q   <= TW'(WALK_T);
    end else if (prog_we) begin
      case (prog_sel)
        SEL_BASE:   dur_base_q   <= prog_data;
        SEL_EXT:    dur_ext_q    <= prog_data;
        SEL_YEL:    dur_yel_q    <= prog_data;
        SEL_ALLRED: dur_allred_q <= prog_data;
        SEL_WALK:   dur_walk_q   <= prog_data;
        default:    ;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      StGreen:  load_dur = dur_base_q;
      StExtend: load_dur = dur_ext_q;
      StYellow: load_dur = dur_yel_q;
      StWalk:   load_dur = dur_walk_q;
      default:  load_dur = dur_allred_q;
    endcase
  end

  multi_phase_signal_ctrl_phase_timer #(
    .TW        (TW),
    .RESET_VAL (ALLRED_T)
  ) u_phase_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .hold     (hold),
    .tick     (tick),
    .duration (load_dur),
    .expired  (expired)
  );

  assign walk_exit = (state_q == StWalk) && expired && !preempt_now;
  assign ext_ok    = sensor[cur_q] && (32'(ext_cnt_q) < MAX_EXT);

  always_comb begin
    walk_clr = '0;
    if (walk_exit) walk_clr[cur_q] = 1'b1;
  end

  assign walk_pending_d = (walk_pending_q & ~walk_clr) | walk_req;

  // Round-robin search; iterating downward lets the nearest successor win, cur itself last.
  always_comb begin
    demand     = sensor | (walk_pending_q & ~walk_clr);
    next_phase = PW'((32'(cur_q) + 32'd1) % N_PHASES);
    idx        = '0;
    for (int k = int'(N_PHASES); k >= 1; k--) begin
      idx = PW'((32'(cur_q) + 32'(k)) % N_PHASES);
      if (demand[idx]) next_phase = idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ext_cnt_d = ext_cnt_q;
    fault_d   = fault_q;
    load      = 1'b0;
    case (state_q)
      StAllRed: begin
        if (expired) begin
          load = 1'b1;
`ifdef SIGNAL_PREEMPT_EN
          if (preempt) begin
            state_d = StPreempt;
            cur_d   = preempt_phase;
          end else
`endif
          if (walk_pending_q[cur_q]) begin
            state_d = StWalk;
          end else begin
            state_d   = StGreen;
            cur_d     = next_phase;
            ext_cnt_d = '0;
          end
        end
      end
      StGreen, StExtend: begin
`ifdef SIGNAL_PREEMPT_EN
        if (preempt && (cur_q != preempt_phase)) begin
          state_d = StYellow;
          load    = 1'b1;
        end else
`endif
        if (expired) begin
          load = 1'b1;
          if (ext_ok) begin
            state_d   = StExtend;
            ext_cnt_d = ext_cnt_q + 1'b1;
          end else begin
            state_d = StYellow;
          end
        end
      end
      StYellow: begin
        if (expired) begin
          state_d = StAllRed;
          load    = 1'b1;
        end
      end
      StWalk: begin
        if (preempt_now) begin
          state_d = StAllRed;
          load    = 1'b1;
        end else if (walk_exit) begin
          state_d   = StGreen;
          cur_d     = next_phase;
          ext_cnt_d = '0;
          load      = 1'b1;
        end
      end
`ifdef SIGNAL_PREEMPT_EN
      StPreempt: begin
        cur_d = preempt_phase;
        if (!preempt) begin
          state_d = StYellow;
          load    = 1'b1;
        end
      end
`endif
      default: begin
        fault_d   = 1'b1;
        state_d   = StAllRed;
        cur_d     = LAST;
        ext_cnt_d = '0;
        load      = 1'b1;
      end
    endcase
  end

  // Lamps are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    walk_d   = '0;
    case (state_d)
`ifdef SIGNAL_PREEMPT_EN
      StGreen, StExtend, StPreempt: begin
`else
      StGreen, StExtend: begin
`endif
        green_d[cur_d] = 1'b1;
        red_d[cur_d]   = 1'b0;
      end
      StYellow: begin
        yellow_d[cur_d] = 1'b1;
        red_d[cur_d]    = 1'b0;
      end
      StWalk:  walk_d[cur_d] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StAllRed;
      cur_q          <= LAST;
      ext_cnt_q      <= '0;
      fault_q        <= 1'b0;
      walk_pending_q <= '0;
      red_q          <= '1;
      yellow_q       <= '0;
      green_q        <= '0;
      walk_q         <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      ext_cnt_q      <= ext_cnt_d;
      fault_q        <= fault_d;
      walk_pending_q <= walk_pending_d;
      red_q          <= red_d;
      yellow_q       <= yellow_d;
      green_q        <= green_d;
      walk_q         <= walk_d;
    end
  end

  assign red          = red_q;
  assign yellow       = yellow_q;
  assign green        = green_q;
  assign walk         = walk_q;
  assign cur_phase    = cur_q;
  assign state        = state_q;
  assign walk_pending = walk_pending_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Directed bench for multi_phase_signal_ctrl: rotation, extension, skipping, walk, reprogramming, reset.
module tb_multi_phase_signal_ctrl;

  localparam logic [2:0] AR = 3'd0, GR = 3'd1, EX = 3'd2, YE = 3'd3, WK = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b1;
  logic [3:0] sensor = '0;
  logic [3:0] walk_req = '0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_sel = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] red, yellow, green, walk, walk_pending;
  logic [1:0] cur_phase;
  logic [2:0] state;
  logic       fault;

  int total = 0;
  int bad = 0;

  multi_phase_signal_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef SIGNAL_PREEMPT_EN
    .preempt      (1'b0),
    .preempt_phase(2'd0),
`endif
    .tick         (tick),
    .sensor       (sensor),
    .walk_req     (walk_req),
    .prog_we      (prog_we),
    .prog_sel     (prog_sel),
    .prog_data    (prog_data),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .walk         (walk),
    .cur_phase    (cur_phase),
    .state        (state),
    .walk_pending (walk_pending),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Checks state/phase on entry, then counts negedges spent there (bounded).
  task automatic dwell(input string tag, input logic [2:0] st, input logic [1:0] ph,
                       input int len);
    int n;
    n = 0;
    chk({tag, ":entry"}, 32'({state, cur_phase}), 32'({st, ph}));
    while (state === st && cur_phase === ph && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ":len"}, n, len);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(AR));
    chk("rst_cur", 32'(cur_phase), 32'd3);
    chk("rst_red", 32'(red), 32'hF);
    chk("rst_grn_yel_walk", 32'({green, yellow, walk}), 32'd0);
    chk("rst_pend_fault", 32'({walk_pending, fault}), 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Plain rotation, no demand
    chk("g0_lamps", 32'({green, red}), 32'h1E);
    dwell("rot_g0", GR, 2'd0, 6);
    chk("y0_lamps", 32'({yellow, red}), 32'h1E);
    dwell("rot_y0", YE, 2'd0, 2);
    chk("ar0_lamps", 32'({green, yellow, red}), 32'h00F);
    dwell("rot_ar0", AR, 2'd0, 1);
    chk("g1_lamps", 32'({green, red}), 32'h2D);
    dwell("rot_g1", GR, 2'd1, 6);
    dwell("rot_y1", YE, 2'd1, 2);
    dwell("rot_ar1", AR, 2'd1, 1);
    dwell("rot_g2", GR, 2'd2, 6);
    dwell("rot_y2", YE, 2'd2, 2);
    dwell("rot_ar2", AR, 2'd2, 1);
    dwell("rot_g3", GR, 2'd3, 6);
    dwell("rot_y3", YE, 2'd3, 2);
    dwell("rot_ar3", AR, 2'd3, 1);

    // Held sensor[1]: two extensions on phase 1
    sensor = 4'b0010;
    dwell("ext_g0", GR, 2'd0, 6);
    dwell("ext_y0", YE, 2'd0, 2);
    dwell("ext_ar0", AR, 2'd0, 1);
    dwell("ext_g1", GR, 2'd1, 6);
    chk("ext_lamps", 32'({green, red}), 32'h2D);
    dwell("ext_e1", EX, 2'd1, 6);
    sensor = 4'b0000;
    dwell("ext_y1", YE, 2'd1, 2);
    dwell("ext_ar1", AR, 2'd1, 1);
    dwell("ext_g2", GR, 2'd2, 6);
    dwell("ext_y2", YE, 2'd2, 2);
    dwell("ext_ar2", AR, 2'd2, 1);
    dwell("ext_g3", GR, 2'd3, 6);
    dwell("ext_y3", YE, 2'd3, 2);
    dwell("ext_ar3", AR, 2'd3, 1);

    // Only sensor[3] while phase 0 served: 1 and 2 skipped
    sensor = 4'b1000;
    dwell("skip_g0", GR, 2'd0, 6);
    dwell("skip_y0", YE, 2'd0, 2);
    dwell("skip_ar0", AR, 2'd0, 1);
    sensor = 4'b0000;
    dwell("skip_g3", GR, 2'd3, 6);
    dwell("skip_y3", YE, 2'd3, 2);
    dwell("skip_ar3", AR, 2'd3, 1);

    // Walk request on phase 2, re-requested on the WALK expiry edge
    chk("walk_g0_entry", 32'({state, cur_phase}), 32'({GR, 2'd0}));
    walk_req = 4'b0100;
    cyc(1);
    walk_req = 4'b0000;
    chk("walk_latched", 32'(walk_pending), 32'h4);
    dwell("walk_g0", GR, 2'd0, 5);
    dwell("walk_y0", YE, 2'd0, 2);
    dwell("walk_ar0", AR, 2'd0, 1);
    dwell("walk_g2", GR, 2'd2, 6);
    dwell("walk_y2", YE, 2'd2, 2);
    dwell("walk_ar2", AR, 2'd2, 1);
    chk("walk_entry", 32'({state, cur_phase}), 32'({WK, 2'd2}));
    chk("walk_lamps", 32'({walk, green, yellow, red}), 32'h400F);
    cyc(3);
    chk("walk_4th_cycle", 32'(state), 32'(WK));
    walk_req = 4'b0100;
    cyc(1);
    walk_req = 4'b0000;
    chk("walk_exit", 32'({state, cur_phase}), 32'({GR, 2'd3}));
    chk("walk_set_wins", 32'(walk_pending), 32'h4);
    chk("walk_lamp_off", 32'(walk), 32'h0);
    dwell("walk_g3", GR, 2'd3, 6);

    // Yellow reprogrammed mid-yellow: current yellow unchanged
    chk("prog_y3_entry", 32'({state, cur_phase}), 32'({YE, 2'd3}));
    prog_we = 1'b1;
    prog_sel = 3'd2;
    prog_data = 8'd5;
    cyc(1);
    prog_we = 1'b0;
    chk("prog_y3_still", 32'(state), 32'(YE));
    cyc(1);
    chk("prog_y3_done", 32'(state), 32'(AR));
    dwell("prog_ar3", AR, 2'd3, 1);
    dwell("prog_g2", GR, 2'd2, 6);
    dwell("prog_y2_new5", YE, 2'd2, 5);
    dwell("prog_ar2", AR, 2'd2, 1);
    dwell("prog_walk2", WK, 2'd2, 4);
    chk("prog_pend_clr", 32'(walk_pending), 32'h0);
    prog_we = 1'b1;
    prog_data = 8'd0;
    cyc(1);
    prog_we = 1'b0;
    dwell("prog_g3", GR, 2'd3, 5);
    dwell("prog_y3_zero", YE, 2'd3, 1);
    dwell("prog_ar3b", AR, 2'd3, 1);

    // Asynchronous reset in the middle of EXTEND
    sensor = 4'b0001;
    dwell("rst_g0", GR, 2'd0, 6);
    chk("rst_ext_entry", 32'({state, cur_phase}), 32'({EX, 2'd0}));
    #2 reset_n = 1'b0;
    #1;
    chk("async_red", 32'({green, yellow, red}), 32'h00F);
    chk("async_state", 32'({state, cur_phase}), 32'({AR, 2'd3}));
    @(negedge clk);
    sensor = 4'b0000;
    reset_n = 1'b1;
    cyc(1);
    chk("post_rst_lamps", 32'({green, red}), 32'h1E);
    dwell("post_rst_g0", GR, 2'd0, 6);
    dwell("post_rst_y0", YE, 2'd0, 2);
    chk("no_fault", 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
